// File: rtl/i_fab_filt.sv
// rtl/i_fab_filt.sv - fabric input bus cell: bypass, synchroniser or synchroniser plus glitch filter
//
// Carries a WIDTH-bit pad-side bus into the fabric. In BYPASS the bus is a plain
// wire. In SYNC and FILTER each bit passes through a SYNC_STAGES-deep synchroniser
// and then a consecutive-sample filter. O[i] only follows the synchronised input
// after that input has differed from O[i] for FILTER_LEN enabled cycles in a row.
// In SYNC mode the filter length is forced to 1, so the filter stage only adds one
// register and the edge-detect pulses.
//
// Ports
//   C     in   1      clock
//   R     in   1      synchronous active-high reset
//   E     in   1      filter enable; low freezes O and the filter counters
//   I     in   WIDTH  asynchronous pad-side input bus
//   O     out  WIDTH  fabric-side output
//   RISE  out  WIDTH  one-cycle pulse per bit when O[i] goes 0->1
//   FALL  out  WIDTH  one-cycle pulse per bit when O[i] goes 1->0

module i_fab_filt #(
  parameter int               WIDTH       = 8,
  parameter string            MODE        = "FILTER",
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 3,
  parameter logic [WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  // SYNC behaves as a filter of length 1: O follows s_out one edge later.
  localparam int EFF_LEN = (MODE == "SYNC") ? 1 : FILTER_LEN;
  // Counter only has to reach EFF_LEN-1, so max(1, clog2(EFF_LEN)) bits suffice.
  localparam int CW      = (EFF_LEN > 2) ? $clog2(EFF_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EFF_LEN - 1);

  if (MODE == "BYPASS") begin : g_bypass

    assign O    = I;
    assign RISE = '0;
    assign FALL = '0;

    // Clock, reset and enable have no function in this mode.
    logic unused_ctrl;
    assign unused_ctrl = ^{C, R, E};

  end else begin : g_reg

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s_out;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    assign s_out = sync_q[SYNC_STAGES-1];

    // Synchroniser runs every edge regardless of E so that re-enabling the
    // filter sees a current input, not a stale one.
    always_ff @(posedge C) begin
      if (R) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= INIT_VALUE;
        end
      end else begin
        sync_q[0] <= I;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    // Per-bit filter. A bit's counter advances only while s_out disagrees with O
    // and restarts on any agreeing cycle, so a short excursion never reaches O.
    // Pulses default low each edge, which limits them to a single cycle.
    always_ff @(posedge C) begin
      if (R) begin
        o_q    <= INIT_VALUE;
        rise_q <= '0;
        fall_q <= '0;
        for (int i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        rise_q <= '0;
        fall_q <= '0;
        if (E) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s_out[i] == o_q[i]) begin
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
              // O changes here, so exactly one of RISE/FALL fires.
              o_q[i]    <= s_out[i];
              cnt_q[i]  <= '0;
              rise_q[i] <= s_out[i];
              fall_q[i] <= ~s_out[i];
            end else begin
              cnt_q[i] <= cnt_q[i] + CW'(1);
            end
          end
        end
      end
    end

    assign O    = o_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

  end

endmodule

// File: tb/tb_i_fab_filt.sv
// tb/tb_i_fab_filt.sv - directed bench for i_fab_filt in FILTER, SYNC and BYPASS modes

module tb_i_fab_filt;

  logic       clk = 1'b0;
  logic       r;
  logic       e;
  logic [7:0] i_f, i_s, i_b;
  logic [7:0] o_f, rise_f, fall_f;
  logic [7:0] o_s, rise_s, fall_s;
  logic [7:0] o_b, rise_b, fall_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i_fab_filt #(.WIDTH(8), .MODE("FILTER"), .SYNC_STAGES(2), .FILTER_LEN(3), .INIT_VALUE(8'h00)) u_filt (
    .C(clk), .R(r), .E(e), .I(i_f), .O(o_f), .RISE(rise_f), .FALL(fall_f)
  );

  i_fab_filt #(.WIDTH(8), .MODE("SYNC"), .SYNC_STAGES(2), .FILTER_LEN(3), .INIT_VALUE(8'h00)) u_sync (
    .C(clk), .R(r), .E(e), .I(i_s), .O(o_s), .RISE(rise_s), .FALL(fall_s)
  );

  i_fab_filt #(.WIDTH(8), .MODE("BYPASS"), .SYNC_STAGES(2), .FILTER_LEN(3), .INIT_VALUE(8'h00)) u_byp (
    .C(clk), .R(r), .E(e), .I(i_b), .O(o_b), .RISE(rise_b), .FALL(fall_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi_cyc;
    int n_rise;
    int n_fall;

    // 1: reset with all-ones input
    r   = 1'b1;
    e   = 1'b0;
    i_f = 8'hFF;
    i_s = 8'h00;
    i_b = 8'h00;
    tick();
    chk("rst_o", o_f, 8'h00);
    chk("rst_rise", rise_f, 8'h00);
    chk("rst_fall", fall_f, 8'h00);
    chk("rst_sync_o", o_s, 8'h00);
    tick();
    chk("rst2_o", o_f, 8'h00);
    i_f = 8'h00;
    r   = 1'b0;
    e   = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("idle_o", o_f, 8'h00);

    // 2: step to A5 lands on edge 5, then back to 00 on edge 5
    i_f = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("step_up_hold", o_f, 8'h00);
      chk("step_up_norise", rise_f, 8'h00);
    end
    tick();
    chk("step_up_o", o_f, 8'hA5);
    chk("step_up_rise", rise_f, 8'hA5);
    chk("step_up_fall", fall_f, 8'h00);
    tick();
    chk("step_up_rise_clr", rise_f, 8'h00);
    chk("step_up_o_keep", o_f, 8'hA5);
    i_f = 8'h00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("step_dn_hold", o_f, 8'hA5);
      chk("step_dn_nofall", fall_f, 8'h00);
    end
    tick();
    chk("step_dn_o", o_f, 8'h00);
    chk("step_dn_fall", fall_f, 8'hA5);
    chk("step_dn_rise", rise_f, 8'h00);
    tick();
    chk("step_dn_fall_clr", fall_f, 8'h00);

    // 3a: 2-cycle glitch on bit 0 is rejected
    i_f = 8'h01;
    tick();
    tick();
    i_f = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("glitch2_o", o_f, 8'h00);
      chk("glitch2_rise", rise_f, 8'h00);
    end

    // 3b: 3-cycle pulse passes as a 3-cycle pulse on O[0]
    hi_cyc = 0;
    n_rise = 0;
    n_fall = 0;
    i_f = 8'h01;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) i_f = 8'h00;
      if (o_f[0]) hi_cyc++;
      if (rise_f[0]) n_rise++;
      if (fall_f[0]) n_fall++;
    end
    chk("pulse3_hi_cycles", hi_cyc, 3);
    chk("pulse3_rises", n_rise, 1);
    chk("pulse3_falls", n_fall, 1);
    chk("pulse3_o_end", o_f, 8'h00);

    // 4: enable freezes the count partway through
    i_f = 8'h0F;
    for (int k = 1; k <= 3; k++) tick();
    chk("en_pre_o", o_f, 8'h00);
    e = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("en_frozen_o", o_f, 8'h00);
      chk("en_frozen_rise", rise_f, 8'h00);
    end
    e = 1'b1;
    tick();
    chk("en_resume1_o", o_f, 8'h00);
    tick();
    chk("en_resume2_o", o_f, 8'h0F);
    chk("en_resume2_rise", rise_f, 8'h0F);
    i_f = 8'h00;
    for (int k = 0; k < 6; k++) tick();
    chk("en_cleanup_o", o_f, 8'h00);

    // 5: reset at edge 4 discards the count
    i_f = 8'hFF;
    for (int k = 1; k <= 3; k++) tick();
    r = 1'b1;
    tick();
    chk("midrst_o", o_f, 8'h00);
    chk("midrst_rise", rise_f, 8'h00);
    chk("midrst_fall", fall_f, 8'h00);
    r = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("postrst_hold", o_f, 8'h00);
      chk("postrst_norise", rise_f, 8'h00);
    end
    tick();
    chk("postrst_o", o_f, 8'hFF);
    chk("postrst_rise", rise_f, 8'hFF);

    // 6a: SYNC mode sees a step on edge 3
    i_s = 8'h3C;
    tick();
    chk("sync_e1", o_s, 8'h00);
    tick();
    chk("sync_e2", o_s, 8'h00);
    tick();
    chk("sync_e3_o", o_s, 8'h3C);
    chk("sync_e3_rise", rise_s, 8'h3C);
    chk("sync_e3_fall", fall_s, 8'h00);
    tick();
    chk("sync_e4_rise", rise_s, 8'h00);

    // 6b: BYPASS is a wire with no pulses
    for (int k = 0; k < 64; k++) begin
      i_b = 8'($urandom);
      #1;
      chk("byp_o", o_b, i_b);
      chk("byp_pulses", rise_b | fall_b, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
